// File: rtl/stream_checker_pkg.sv
// stream_checker_pkg: shared types and helpers for the stream checker.
//   state_t   - run-control states (IDLE, RUN, DONE)
//   EXT_W     - width that samples are extended to before subtraction
//   abs_diff  - |a-b| of two pre-extended operands
package stream_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Samples up to 64 bits are sign/zero-extended to EXT_W before subtracting.
  // One guard bit above WIDTH is enough to hold the signed difference
  // without overflow, so the wide result equals the WIDTH+1-bit difference.
  // Synthesis trims the unused upper bits.
  localparam int EXT_W = 65;

  function automatic logic [EXT_W-1:0] abs_diff(input logic [EXT_W-1:0] a,
                                                input logic [EXT_W-1:0] b);
    logic [EXT_W-1:0] d;
    d = a - b;
    return d[EXT_W-1] ? (~d + 1'b1) : d;
  endfunction

endpackage

// File: rtl/stream_checker_if.sv
// stream_checker_if: sample bus into the checker.
//   valid    - one sample per asserted cycle
//   actual   - CHANNELS*WIDTH DUT outputs, channel 0 in LSBs
//   expected - CHANNELS*WIDTH reference values, same packing
//   mask     - per-channel enable, 1 = checked
// master drives the bus, slave (the checker) receives it.
interface stream_checker_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
);
  import stream_checker_pkg::*;

  logic                      valid;
  logic [CHANNELS*WIDTH-1:0] actual;
  logic [CHANNELS*WIDTH-1:0] expected;
  logic [CHANNELS-1:0]       mask;

  modport master (output valid, actual, expected, mask);
  modport slave  (input  valid, actual, expected, mask);

endinterface

// File: rtl/stream_checker_channel.sv
// checker_channel: compare one channel of one sample and keep its score.
//   clk, rst_n - clock, async active-low reset
//   clear      - start of a new run, zeroes flag and counter
//   accept     - a sample is being taken this cycle
//   en         - mask bit for this channel
//   act, exp_v - actual and expected sample
//   hit        - combinational mismatch of the current inputs (masked)
//   mis        - registered mismatch of the last accepted sample
//   cnt        - saturating error counter
module checker_channel
  import stream_checker_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter int unsigned TOL         = 0,
  parameter bit          SIGNED_DATA = 1'b0,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 accept,
  input  logic                 en,
  input  logic [WIDTH-1:0]     act,
  input  logic [WIDTH-1:0]     exp_v,
  output logic                 hit,
  output logic                 mis,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [EXT_W-1:0] act_x, exp_x;

  generate
    if (SIGNED_DATA) begin : g_sext
      assign act_x = {{(EXT_W-WIDTH){act[WIDTH-1]}}, act};
      assign exp_x = {{(EXT_W-WIDTH){exp_v[WIDTH-1]}}, exp_v};
    end else begin : g_zext
      assign act_x = {{(EXT_W-WIDTH){1'b0}}, act};
      assign exp_x = {{(EXT_W-WIDTH){1'b0}}, exp_v};
    end
  endgenerate

  assign hit = en && (abs_diff(act_x, exp_x) > EXT_W'(TOL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis <= 1'b0;
      cnt <= '0;
    end else if (clear) begin
      mis <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      mis <= hit;
      // hold at all-ones instead of wrapping
      if (hit && cnt != {CNT_WIDTH{1'b1}}) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stream_checker.sv
// stream_checker: compares a multi-channel sample stream against reference
// values over a start/stop delimited run and reports a pass verdict.
//   clk, rst_n          - clock, async active-low reset
//   start, stop         - single-cycle run control pulses
//   s                   - sample bus (valid/actual/expected/mask)
//   busy, done          - in RUN / in DONE
//   test_passed         - verdict, valid while done=1
//   mismatch            - per-channel flags of the last accepted sample
//   err_count           - per-channel saturating error counters
//   sample_count        - samples accepted in this run (wraps at 2^32)
//   first_err_*         - record of the first mismatching sample of the run
module stream_checker
  import stream_checker_pkg::*;
#(
  parameter int          CHANNELS    = 4,
  parameter int          WIDTH       = 16,
  parameter int unsigned TOL         = 0,
  parameter bit          SIGNED_DATA = 1'b0,
  parameter int          CNT_WIDTH   = 16,
  parameter int unsigned MAX_SAMPLES = 0,
  localparam int         CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stop,
  stream_checker_if.slave               s,
  output logic                          busy,
  output logic                          done,
  output logic                          test_passed,
  output logic [CHANNELS-1:0]           mismatch,
  output logic [CHANNELS*CNT_WIDTH-1:0] err_count,
  output logic [31:0]                   sample_count,
  output logic                          first_err_valid,
  output logic [CW-1:0]                 first_err_chan,
  output logic [31:0]                   first_err_index
);

  state_t              state;
  logic                clear, accept, last;
  logic [CHANNELS-1:0] hit;
  logic [CW-1:0]       low_chan;
  logic [31:0]         cnt_nxt, cnt_after;
  logic                fev_after;

  // A start outside RUN opens a new run; the channels clear on that edge.
  assign clear  = start && (state != RUN);
  assign accept = s.valid && (state == RUN);

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      checker_channel #(
        .WIDTH      (WIDTH),
        .TOL        (TOL),
        .SIGNED_DATA(SIGNED_DATA),
        .CNT_WIDTH  (CNT_WIDTH)
      ) u_ch (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .accept(accept),
        .en    (s.mask[c]),
        .act   (s.actual[c*WIDTH +: WIDTH]),
        .exp_v (s.expected[c*WIDTH +: WIDTH]),
        .hit   (hit[c]),
        .mis   (mismatch[c]),
        .cnt   (err_count[c*CNT_WIDTH +: CNT_WIDTH])
      );
    end
  endgenerate

  // Lowest mismatching channel: scan downward so the lowest index wins.
  always_comb begin
    low_chan = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (hit[i]) low_chan = CW'(i);
  end

  // Values the run ends with if it ends this cycle, so the verdict can be
  // registered together with the move into DONE.
  always_comb begin
    cnt_nxt   = sample_count + 32'd1;
    cnt_after = accept ? cnt_nxt : sample_count;
    fev_after = first_err_valid | (accept & (|hit));
    last      = stop || (accept && (MAX_SAMPLES != 0) &&
                         (cnt_nxt == 32'(MAX_SAMPLES)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      test_passed     <= 1'b0;
      sample_count    <= '0;
      first_err_valid <= 1'b0;
      first_err_chan  <= '0;
      first_err_index <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= RUN;
            busy            <= 1'b1;
            done            <= 1'b0;
            test_passed     <= 1'b0;
            sample_count    <= '0;
            first_err_valid <= 1'b0;
            first_err_chan  <= '0;
            first_err_index <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            sample_count <= cnt_nxt;
            if (!first_err_valid && (|hit)) begin
              first_err_valid <= 1'b1;
              first_err_chan  <= low_chan;
              first_err_index <= sample_count;
            end
          end
          if (last) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            test_passed <= !fev_after && (cnt_after != 32'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
